// File: rtl/prom_loader.sv
// Serial boot loader: 16-bit LE word count, then N little-endian 32-bit words written to boot memory.
// Define PROM_LOADER_CKSUM_EN to require a trailing 8-bit additive checksum byte before FINISH.
module prom_loader #(
  parameter int TIMEOUT  = 100000,
  parameter int MAXWORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        rx_done,
  output logic        wr_en,
  output logic [8:0]  wr_adr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, CKSUM, FINISH, FAIL
  } state_t;

  state_t         state, state_nxt;
  logic [15:0]    word_cnt;
  logic [1:0]     byte_idx;
  logic [TW-1:0]  idle_cnt;
  logic           accept, arm, last_word, timed_out;
  logic [15:0]    cnt_full;
`ifdef PROM_LOADER_CKSUM_EN
  logic [7:0]     cksum;
`endif

  assign busy      = (state == CNT_LO) || (state == CNT_HI) ||
                     (state == DATA)   || (state == CKSUM);
  // rx_done doubles as the "byte just taken" marker, so rx_rdy is ignored while it is high.
  assign accept    = rx_rdy && busy && !rx_done;
  assign arm       = start && ((state == IDLE) || (state == FINISH) || (state == FAIL));
  assign cnt_full  = {rx_data, word_cnt[7:0]};
  assign last_word = wr_en && ({7'd0, wr_adr} == (word_cnt - 16'd1));
  assign timed_out = busy && (idle_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH, FAIL: if (start) state_nxt = CNT_LO;
      CNT_LO: if (accept) state_nxt = CNT_HI;
      CNT_HI: if (accept) begin
        if ((cnt_full == 16'd0) || (int'(cnt_full) > MAXWORDS)) state_nxt = FAIL;
        else                                                    state_nxt = DATA;
      end
`ifdef PROM_LOADER_CKSUM_EN
      DATA:  if (last_word) state_nxt = CKSUM;
      CKSUM: if (accept) state_nxt = (rx_data == cksum) ? FINISH : FAIL;
`else
      DATA:  if (last_word) state_nxt = FINISH;
      CKSUM: state_nxt = FINISH;
`endif
      default: state_nxt = IDLE;
    endcase
    if (timed_out) state_nxt = FAIL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done  <= 1'b0;
      wr_en    <= 1'b0;
      wr_adr   <= 9'd0;
      wr_data  <= 32'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      word_cnt <= 16'd0;
      byte_idx <= 2'd0;
      idle_cnt <= '0;
`ifdef PROM_LOADER_CKSUM_EN
      cksum    <= 8'd0;
`endif
    end else begin
      rx_done <= accept;
      wr_en   <= 1'b0;

      // Idle time is measured per state: any progress or state change restarts it.
      if (accept || (state_nxt != state)) idle_cnt <= '0;
      else if (busy)                      idle_cnt <= idle_cnt + TW'(1);

      if (arm) begin
        done     <= 1'b0;
        err      <= 1'b0;
        wr_adr   <= 9'd0;
        word_cnt <= 16'd0;
        byte_idx <= 2'd0;
`ifdef PROM_LOADER_CKSUM_EN
        cksum    <= 8'd0;
`endif
      end

      if ((state_nxt == FINISH) && (state != FINISH)) done <= 1'b1;
      if ((state_nxt == FAIL)   && (state != FAIL))   err  <= 1'b1;

      if (accept) begin
        case (state)
          CNT_LO: word_cnt[7:0]  <= rx_data;
          CNT_HI: word_cnt[15:8] <= rx_data;
          DATA: begin
            wr_data[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
`ifdef PROM_LOADER_CKSUM_EN
            cksum    <= cksum + rx_data;
`endif
            // A word completed in the same cycle as a timeout is dropped.
            if ((byte_idx == 2'd3) && (state_nxt == DATA)) wr_en <= 1'b1;
          end
          default: ;
        endcase
      end

      // wr_en always coincides with rx_done, so no byte is accepted in this cycle.
      if (wr_en && !last_word) wr_adr <= wr_adr + 9'd1;
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Directed bench for prom_loader (TIMEOUT=100); builds with or without PROM_LOADER_CKSUM_EN.
module tb_prom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_rdy = 1'b0;
  logic        rx_done, wr_en, busy, done, err;
  logic [8:0]  wr_adr;
  logic [31:0] wr_data;

  int checks = 0;
  int failures = 0;
  logic [8:0]  adr_q[$];
  logic [31:0] dat_q[$];

  prom_loader #(.TIMEOUT(100), .MAXWORDS(512)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .rx_done(rx_done), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      adr_q.push_back(wr_adr);
      dat_q.push_back(wr_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Returns in the rx_done cycle with rx_rdy dropped.
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data = b;
    rx_rdy  = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!rx_done && n < 50);
    if (!rx_done) check("rx_done_wait", {31'd0, rx_done}, 32'd1);
    rx_rdy = 1'b0;
  endtask

  task automatic clear_log();
    adr_q.delete();
    dat_q.delete();
  endtask

  initial begin
    int bad_adr, bad_dat;
    logic [31:0] w;
    logic [7:0]  cs;
    logic [5:0]  rd_pat;

    // Reset state
    tick(3);
    check("rst_outputs", {25'd0, rx_done, wr_en, busy, done, err, 2'd0}, 32'd0);
    check("rst_wr_adr", {23'd0, wr_adr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    rst = 1'b0;
    tick(2);

    // Single word
    clear_log();
    pulse_start();
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
`ifdef PROM_LOADER_CKSUM_EN
    tick(1);
    send_byte(8'h14);
`endif
    tick(2);
    check("t1_wr_count", adr_q.size(), 1);
    if (adr_q.size() > 0) begin
      check("t1_wr_adr", {23'd0, adr_q[0]}, 32'd0);
      check("t1_wr_data", dat_q[0], 32'h12345678);
    end
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Full depth N=512
    clear_log();
    pulse_start();
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    send_byte(8'h00); send_byte(8'h02);
    cs = 8'd0;
    for (int k = 0; k < 2048; k++) begin
      send_byte(8'(k * 7 + 3));
      cs = cs + 8'(k * 7 + 3);
    end
`ifdef PROM_LOADER_CKSUM_EN
    tick(1);
    send_byte(cs);
`endif
    tick(2);
    check("t2_wr_count", adr_q.size(), 512);
    bad_adr = 0;
    bad_dat = 0;
    for (int i = 0; i < adr_q.size(); i++) begin
      for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((4 * i + j) * 7 + 3);
      if (adr_q[i] != 9'(i)) bad_adr++;
      if (dat_q[i] != w)     bad_dat++;
    end
    check("t2_adr_order_errors", bad_adr, 0);
    check("t2_data_errors", bad_dat, 0);
    check("t2_final_wr_adr", {23'd0, wr_adr}, 32'd511);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_err", {31'd0, err}, 32'd0);

    // N=513 rejected right after count
    clear_log();
    pulse_start();
    send_byte(8'h01); send_byte(8'h02);
    check("t3_err_immediate", {31'd0, err}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_done", {31'd0, done}, 32'd0);
    tick(3);
    check("t3_wr_count", adr_q.size(), 0);

    // Timeout after 2 data bytes (restart from FAIL)
    clear_log();
    pulse_start();
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    tick(95);
    check("t4_no_err_before_timeout", {31'd0, err}, 32'd0);
    check("t4_busy_before_timeout", {31'd0, busy}, 32'd1);
    tick(10);
    check("t4_err_after_timeout", {31'd0, err}, 32'd1);
    check("t4_busy_after_timeout", {31'd0, busy}, 32'd0);
    check("t4_wr_count", adr_q.size(), 0);

`ifdef PROM_LOADER_CKSUM_EN
    // Bad checksum
    clear_log();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    tick(1);
    send_byte(8'h15);
    tick(2);
    check("t5_wr_count", adr_q.size(), 1);
    check("t5_err", {31'd0, err}, 32'd1);
    check("t5_done", {31'd0, done}, 32'd0);
`endif

    // rx_rdy held high, start during busy, reset mid-load
    clear_log();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    rx_data = 8'h11;
    rx_rdy  = 1'b1;
    rd_pat  = 6'd0;
    for (int c = 0; c < 6; c++) begin
      start = (c == 2);
      tick(1);
      rd_pat[c] = rx_done;
    end
    start  = 1'b0;
    rx_rdy = 1'b0;
    check("t6_rx_done_pattern", {26'd0, rd_pat}, 32'h2A);
    check("t6_busy_after_start_ignored", {31'd0, busy}, 32'd1);
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h11);
    tick(1);
    check("t6_wr_count_before_rst", adr_q.size(), 1);
    if (dat_q.size() > 0) check("t6_word0_data", dat_q[0], 32'h11111111);
    rst = 1'b1;
    #1;
    check("t6_rst_outputs", {25'd0, rx_done, wr_en, busy, done, err, 2'd0}, 32'd0);
    check("t6_rst_wr_adr", {23'd0, wr_adr}, 32'd0);
    check("t6_rst_wr_data", wr_data, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(5);
    check("t6_wr_count_after_rst", adr_q.size(), 1);
    check("t6_busy_after_rst", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prom_loader.md
PROM_LOADER -- requirements
Module: prom_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 100000, meaning the maximum number of idle clk cycles allowed between bytes while loading.
REQ-002 SHALL have parameter MAXWORDS, default 512, meaning the boot memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that arms a load.
REQ-006 SHALL have port rx_data, input, 8 bits: received byte.
REQ-007 SHALL have port rx_rdy, input, 1 bit: a byte is available on rx_data.
REQ-008 SHALL have port rx_done, output, 1 bit: single-cycle acknowledge that the byte was consumed.
REQ-009 SHALL have port wr_en, output, 1 bit: single-cycle write strobe to the boot memory.
REQ-010 SHALL have port wr_adr, output, 9 bits: boot memory word address.
REQ-011 SHALL have port wr_data, output, 32 bits: boot memory write word.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress (holds the CPU in reset).
REQ-013 SHALL have port done, output, 1 bit: the last load completed successfully.
REQ-014 SHALL have port err, output, 1 bit: the last load failed.

Function
REQ-015 SHALL implement states IDLE, CNT_LO, CNT_HI, DATA, CKSUM, FINISH and FAIL.
REQ-016 SHALL leave IDLE/FINISH/FAIL for CNT_LO on start, clearing done, err, wr_adr, the byte index and the checksum; start in any other state SHALL be ignored.
REQ-017 SHALL assert busy exactly in CNT_LO, CNT_HI, DATA and CKSUM.
REQ-018 SHALL accept a byte in a cycle where rx_rdy=1, state is busy and rx_done=0, and SHALL pulse rx_done high for exactly the next cycle; rx_rdy SHALL be ignored during that rx_done cycle.
REQ-019 SHALL take the word count N as 16-bit little-endian (CNT_LO byte, then CNT_HI byte).
REQ-020 SHALL go to FAIL after CNT_HI when N=0 or N>MAXWORDS, otherwise to DATA.
REQ-021 SHALL assemble each group of 4 data bytes little-endian (first byte = bits 7:0) into wr_data.
REQ-022 SHALL pulse wr_en for one cycle, the cycle after the 4th byte of a word is accepted, with wr_adr holding that word's index.
REQ-023 SHALL increment wr_adr after each wr_en, starting at 0; after word N-1 the FSM SHALL go to CKSUM (or FINISH, see Configuration), leaving wr_adr at N-1.
REQ-024 SHALL keep a per-state idle counter, cleared on each accepted byte, and SHALL go to FAIL when it reaches TIMEOUT while busy.
REQ-025 SHALL set done=1 on entry to FINISH and err=1 on entry to FAIL; both SHALL hold until the next start.
REQ-026 SHALL never assert wr_en outside DATA; a word partially received at FAIL SHALL NOT be written.

Reset
REQ-027 SHALL, on rst=1, asynchronously force state IDLE and rx_done=0, wr_en=0, wr_adr=0, wr_data=0, busy=0, done=0, err=0, and clear all counters.
REQ-028 SHALL, on reset mid-load, abandon the load with no further wr_en; words already written are not retracted.

Configuration
REQ-029 SHALL, with macro PROM_LOADER_CKSUM_EN defined, expect after the last data byte one checksum byte equal to the 8-bit sum modulo 256 of all N*4 data bytes; a match SHALL go to FINISH and a mismatch SHALL go to FAIL.
REQ-030 SHALL, without PROM_LOADER_CKSUM_EN, omit CKSUM and go directly to FINISH the cycle after the final wr_en.

Verification
REQ-031 SHALL cover: start, bytes 01 00 78 56 34 12 [CKSUM 14] -> one wr_en with adr 0, data 32'h12345678; done=1, err=0, busy=0.
REQ-032 SHALL cover: count bytes 00 02 (N=512), then 2048 data bytes -> 512 wr_en pulses with adr 0..511 in order; done=1.
REQ-033 SHALL cover: count bytes 01 02 (N=513) -> FAIL right after the 2nd byte; err=1; no wr_en.
REQ-034 SHALL cover: with TIMEOUT=100, stop after 2 data bytes -> err=1 at idle count 100; no wr_en.
REQ-035 SHALL cover: with PROM_LOADER_CKSUM_EN, checksum byte 15 instead of 14 -> wr_en for word 0 occurs, then err=1, done=0.
REQ-036 SHALL cover: rst pulse after 6 of 8 data bytes -> all outputs 0 immediately; start pulse during busy ignored; rx_rdy held high -> rx_done pulses every 2nd cycle.
